pytxaclbufctrl: RTL and testbench

- ACL transmit payload buffer controller; the transmit-direction counterpart of the ACL receive buffer control.
- Baseband state machine (bsm, host side) loads outgoing ACL payloads into two ping-pong 256x32 single-port SRAMs. The link controller (lnctrl) reads the current buffer for transmission.
- Buffers are released only on a positive ARQN acknowledge. SEQN is toggled per new payload, and remote FLOW=0 is honoured (Vol2 Part B ch 4.5).

---
 rtl/pytxaclbufctrl.sv | 156 +++++++++++++++
 tb/tb_pytxaclbufctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pytxaclbufctrl.sv
// ACL transmit payload buffer controller: two ping-pong 256x32 single-port buffers loaded by bsm,
// read by lnctrl, released only on positive ARQN, with SEQN tracking and remote FLOW honouring.
module pytxaclbufctrl (
    input  logic        clk_6M,
    input  logic        rst,
    input  logic [7:0]  bsm_addr,
    input  logic [31:0] bsm_din,
    input  logic        bsm_we,
    input  logic        bsm_loadend_p,
    input  logic [9:0]  bsm_pylenByte,
    input  logic [7:0]  lnctrl_addr,
    input  logic        lnctrl_rd,
    input  logic        tx_packet_st_p,
    input  logic        tx_pktype_data,
    input  logic        rx_hdr_p,
    input  logic        rx_hecgood,
    input  logic        rx_arqn,
    input  logic        rx_flow,
    input  logic        flush_p,
    output logic [31:0] lnctrl_dout,
    output logic [9:0]  tx_pylenByte,
    output logic        txbuf_valid,
    output logic        tx_seqn,
    output logic        regi_acltxbuffull
);

    logic       wr_sel_q, wr_sel_d;
    logic       rd_sel_q, rd_sel_d;
    logic [1:0] full_q, full_d;
    logic [9:0] len_q [2];
    logic [9:0] len_d [2];
    logic       sent_q, sent_d;
    logic       flow_stop_q, flow_stop_d;
    logic       tx_seqn_q, tx_seqn_d;

    // SRAM port signals, one set per buffer
    logic [1:0]  own;
    logic [7:0]  sram_a    [2];
    logic [31:0] sram_din  [2];
    logic [1:0]  sram_we;
    logic [1:0]  sram_cs;
    logic [31:0] sram_dout [2];
    logic [31:0] mem0 [256];
    logic [31:0] mem1 [256];

    // A buffer belongs to bsm only while it is the write target and still empty
    always_comb begin
        own[0] = ~wr_sel_q & ~full_q[0];
        own[1] =  wr_sel_q & ~full_q[1];
        for (int b = 0; b < 2; b++) begin
            sram_a[b]   = lnctrl_addr;
            sram_din[b] = 32'd0;
            sram_we[b]  = 1'b0;
            sram_cs[b]  = lnctrl_rd;
            if (own[b]) begin
                sram_a[b]   = bsm_addr;
                sram_din[b] = bsm_din;
                sram_we[b]  = bsm_we;
                sram_cs[b]  = bsm_we;
            end
        end
    end

    always_ff @(posedge clk_6M) begin
        if (sram_cs[0]) begin
            if (sram_we[0]) begin
                mem0[sram_a[0]] <= sram_din[0];
            end else begin
                sram_dout[0] <= mem0[sram_a[0]];
            end
        end
    end

    always_ff @(posedge clk_6M) begin
        if (sram_cs[1]) begin
            if (sram_we[1]) begin
                mem1[sram_a[1]] <= sram_din[1];
            end else begin
                sram_dout[1] <= mem1[sram_a[1]];
            end
        end
    end

    always_comb begin
        lnctrl_dout       = rd_sel_q ? sram_dout[1] : sram_dout[0];
        tx_pylenByte      = len_q[rd_sel_q];
        txbuf_valid       = full_q[rd_sel_q] & ~flow_stop_q;
        tx_seqn           = tx_seqn_q;
        regi_acltxbuffull = &full_q;
    end

    always_comb begin
        wr_sel_d    = wr_sel_q;
        rd_sel_d    = rd_sel_q;
        full_d      = full_q;
        len_d[0]    = len_q[0];
        len_d[1]    = len_q[1];
        sent_d      = sent_q;
        flow_stop_d = flow_stop_q;
        tx_seqn_d   = tx_seqn_q;

        if (flush_p) begin
            // Remote sequence/flow state is unaffected by a local flush
            wr_sel_d = 1'b0;
            rd_sel_d = 1'b0;
            full_d   = 2'b00;
            sent_d   = 1'b0;
        end else begin
            if (bsm_loadend_p && !full_q[wr_sel_q]) begin
                full_d[wr_sel_q] = 1'b1;
                len_d[wr_sel_q]  = bsm_pylenByte;
                wr_sel_d         = ~wr_sel_q;
            end

            // An unanswered earlier transmission is treated as NAK
            if (tx_packet_st_p) begin
                sent_d = tx_pktype_data & txbuf_valid;
            end

            if (rx_hdr_p) begin
                sent_d = 1'b0;
                if (rx_hecgood) begin
                    flow_stop_d = ~rx_flow;
                    if (sent_q && rx_arqn) begin
                        full_d[rd_sel_q] = 1'b0;
                        rd_sel_d         = ~rd_sel_q;
                        tx_seqn_d        = ~tx_seqn_q;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_6M or posedge rst) begin
        if (rst) begin
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
            full_q      <= 2'b00;
            len_q[0]    <= 10'd0;
            len_q[1]    <= 10'd0;
            sent_q      <= 1'b0;
            flow_stop_q <= 1'b0;
            tx_seqn_q   <= 1'b0;
        end else begin
            wr_sel_q    <= wr_sel_d;
            rd_sel_q    <= rd_sel_d;
            full_q      <= full_d;
            len_q[0]    <= len_d[0];
            len_q[1]    <= len_d[1];
            sent_q      <= sent_d;
            flow_stop_q <= flow_stop_d;
            tx_seqn_q   <= tx_seqn_d;
        end
    end

endmodule

// File: tb/tb_pytxaclbufctrl.sv
// Scoreboard bench for pytxaclbufctrl: stimulus pushes expected read data and status,
// a negedge monitor pops and compares.
module tb_pytxaclbufctrl;

    logic        clk_6M = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  bsm_addr = '0;
    logic [31:0] bsm_din = '0;
    logic        bsm_we = 1'b0;
    logic        bsm_loadend_p = 1'b0;
    logic [9:0]  bsm_pylenByte = '0;
    logic [7:0]  lnctrl_addr = '0;
    logic        lnctrl_rd = 1'b0;
    logic        tx_packet_st_p = 1'b0;
    logic        tx_pktype_data = 1'b0;
    logic        rx_hdr_p = 1'b0;
    logic        rx_hecgood = 1'b0;
    logic        rx_arqn = 1'b0;
    logic        rx_flow = 1'b0;
    logic        flush_p = 1'b0;
    logic [31:0] lnctrl_dout;
    logic [9:0]  tx_pylenByte;
    logic        txbuf_valid;
    logic        tx_seqn;
    logic        regi_acltxbuffull;

    pytxaclbufctrl dut (
        .clk_6M            (clk_6M),
        .rst               (rst),
        .bsm_addr          (bsm_addr),
        .bsm_din           (bsm_din),
        .bsm_we            (bsm_we),
        .bsm_loadend_p     (bsm_loadend_p),
        .bsm_pylenByte     (bsm_pylenByte),
        .lnctrl_addr       (lnctrl_addr),
        .lnctrl_rd         (lnctrl_rd),
        .tx_packet_st_p    (tx_packet_st_p),
        .tx_pktype_data    (tx_pktype_data),
        .rx_hdr_p          (rx_hdr_p),
        .rx_hecgood        (rx_hecgood),
        .rx_arqn           (rx_arqn),
        .rx_flow           (rx_flow),
        .flush_p           (flush_p),
        .lnctrl_dout       (lnctrl_dout),
        .tx_pylenByte      (tx_pylenByte),
        .txbuf_valid       (txbuf_valid),
        .tx_seqn           (tx_seqn),
        .regi_acltxbuffull (regi_acltxbuffull)
    );

    always #5 clk_6M = ~clk_6M;

    // Status vector: {txbuf_valid, tx_pylenByte, tx_seqn, regi_acltxbuffull}
    typedef struct {
        string       name;
        logic [12:0] exp;
    } stat_t;

    stat_t       stat_q [$];
    logic [31:0] rd_q [$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic        rd_d = 1'b0;
    stat_t       s_cur;
    logic [12:0] s_act;
    logic [31:0] r_exp;

    always @(posedge clk_6M) rd_d <= lnctrl_rd;

    always @(negedge clk_6M) begin
        if (rd_d) begin
            n_chk++;
            if (rd_q.size() == 0) begin
                n_fail++;
                $display("FAIL rd_unexpected: got %h, no read data expected", lnctrl_dout);
            end else begin
                r_exp = rd_q.pop_front();
                if (lnctrl_dout !== r_exp) begin
                    n_fail++;
                    $display("FAIL rd_data: got %h, expected %h", lnctrl_dout, r_exp);
                end
            end
        end
        if (stat_q.size() != 0) begin
            s_cur = stat_q.pop_front();
            s_act = {txbuf_valid, tx_pylenByte, tx_seqn, regi_acltxbuffull};
            n_chk++;
            if (s_act !== s_cur.exp) begin
                n_fail++;
                $display("FAIL %s: got valid=%b len=%0d seqn=%b full=%b, expected valid=%b len=%0d seqn=%b full=%b",
                         s_cur.name, s_act[12], s_act[11:2], s_act[1], s_act[0],
                         s_cur.exp[12], s_cur.exp[11:2], s_cur.exp[1], s_cur.exp[0]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk_6M);
        #1;
    endtask

    task automatic chk(input string nm, input logic v, input logic [9:0] l, input logic sq,
                       input logic f);
        stat_t e;
        e.name = nm;
        e.exp  = {v, l, sq, f};
        stat_q.push_back(e);
        cyc();
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        bsm_addr = a;
        bsm_din  = d;
        bsm_we   = 1'b1;
        cyc();
        bsm_we   = 1'b0;
    endtask

    task automatic loadend(input logic [9:0] len);
        bsm_loadend_p = 1'b1;
        bsm_pylenByte = len;
        cyc();
        bsm_loadend_p = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] exp);
        lnctrl_addr = a;
        lnctrl_rd   = 1'b1;
        rd_q.push_back(exp);
        cyc();
        lnctrl_rd   = 1'b0;
    endtask

    task automatic tx(input logic data);
        tx_packet_st_p = 1'b1;
        tx_pktype_data = data;
        cyc();
        tx_packet_st_p = 1'b0;
        tx_pktype_data = 1'b0;
    endtask

    task automatic rx(input logic hec, input logic arqn, input logic flow);
        rx_hdr_p   = 1'b1;
        rx_hecgood = hec;
        rx_arqn    = arqn;
        rx_flow    = flow;
        cyc();
        rx_hdr_p   = 1'b0;
    endtask

    initial begin
        int guard;
        repeat (2) cyc();
        chk("reset_held", 1'b0, 10'd0, 1'b0, 1'b0);
        rst = 1'b0;
        chk("reset_state", 1'b0, 10'd0, 1'b0, 1'b0);

        // 17 bytes into buf0
        for (int i = 0; i < 5; i++) wr(8'(i), 32'hA000_0000 + 32'(i));
        loadend(10'd17);
        chk("load17", 1'b1, 10'd17, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) rd(8'(i), 32'hA000_0000 + 32'(i));

        tx(1'b1);
        rx(1'b1, 1'b1, 1'b1);
        chk("ack_buf0", 1'b0, 10'd0, 1'b1, 1'b0);

        // buf1: NAK, bad HEC, and intervening non-data packet all retain it
        for (int i = 0; i < 4; i++) wr(8'(i), 32'hB000_0000 + 32'(i));
        loadend(10'd13);
        chk("load13_buf1", 1'b1, 10'd13, 1'b1, 1'b0);
        tx(1'b1);
        rx(1'b1, 1'b0, 1'b1);
        chk("nak_retain", 1'b1, 10'd13, 1'b1, 1'b0);
        rd(8'd0, 32'hB000_0000);
        tx(1'b1);
        rx(1'b0, 1'b1, 1'b1);
        chk("badhec_retain", 1'b1, 10'd13, 1'b1, 1'b0);
        rd(8'd1, 32'hB000_0001);
        tx(1'b1);
        tx(1'b0);
        rx(1'b1, 1'b1, 1'b1);
        chk("nondata_clears_sent", 1'b1, 10'd13, 1'b1, 1'b0);
        tx(1'b1);
        rx(1'b1, 1'b1, 1'b1);
        chk("ack_buf1", 1'b0, 10'd17, 1'b0, 1'b0);

        // fill both buffers, then try a third load
        for (int i = 0; i < 3; i++) wr(8'(i), 32'hC000_0000 + 32'(i));
        loadend(10'd9);
        wr(8'd0, 32'hD000_0000);
        loadend(10'd4);
        chk("both_full", 1'b1, 10'd9, 1'b0, 1'b1);
        wr(8'd0, 32'hEEEE_EEEE);
        loadend(10'd20);
        chk("third_load_ignored", 1'b1, 10'd9, 1'b0, 1'b1);
        rd(8'd0, 32'hC000_0000);
        tx(1'b1);
        rx(1'b1, 1'b1, 1'b1);
        chk("ack_frees_buf0", 1'b1, 10'd4, 1'b1, 1'b0);
        rd(8'd0, 32'hD000_0000);
        wr(8'd0, 32'hE000_0000);
        loadend(10'd8);
        chk("reload_buf0", 1'b1, 10'd4, 1'b1, 1'b1);

        // remote flow control
        rx(1'b1, 1'b0, 1'b0);
        chk("flow_stop", 1'b0, 10'd4, 1'b1, 1'b1);
        tx(1'b1);
        rx(1'b1, 1'b1, 1'b0);
        chk("no_tx_while_stopped", 1'b0, 10'd4, 1'b1, 1'b1);
        rx(1'b0, 1'b0, 1'b1);
        chk("badhec_flow_held", 1'b0, 10'd4, 1'b1, 1'b1);
        rx(1'b1, 1'b0, 1'b1);
        chk("flow_go", 1'b1, 10'd4, 1'b1, 1'b1);

        // flush together with loadend and ack
        tx(1'b1);
        flush_p       = 1'b1;
        bsm_loadend_p = 1'b1;
        bsm_pylenByte = 10'd30;
        rx_hdr_p      = 1'b1;
        rx_hecgood    = 1'b1;
        rx_arqn       = 1'b1;
        rx_flow       = 1'b1;
        cyc();
        flush_p       = 1'b0;
        bsm_loadend_p = 1'b0;
        rx_hdr_p      = 1'b0;
        chk("flush", 1'b0, 10'd8, 1'b1, 1'b0);
        wr(8'd0, 32'hF000_0000);
        loadend(10'd5);
        chk("post_flush_buf0", 1'b1, 10'd5, 1'b1, 1'b0);
        rd(8'd0, 32'hF000_0000);
        wr(8'd0, 32'h1111_1111);
        loadend(10'd6);
        chk("post_flush_buf1", 1'b1, 10'd5, 1'b1, 1'b1);

        guard = 0;
        while ((stat_q.size() != 0 || rd_q.size() != 0) && guard < 20) begin
            cyc();
            guard++;
        end
        if (stat_q.size() != 0 || rd_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: got %0d status and %0d reads pending, expected 0",
                     stat_q.size(), rd_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
